memory_cycle_dual: RTL and testbench

- Memory stage for the dual-PE (PE1/PE2) pipeline. It sits directly upstream of the writeback stage and drives every W-stage signal that stage consumes.
- Contains one shared single-port synchronous data memory, the PE1/PE2 access arbiter, and the MEM/WB pipeline registers.
- When both PEs request memory in the same cycle, their accesses are serialised in program order (PE1 before PE2). A stall holds upstream stages while this happens.

---
 rtl/memory_cycle_dual.sv | 189 ++++++++++++++++++
 tb/tb_memory_cycle_dual.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle_dual.sv
// memory_cycle_dual: dual-PE memory stage with one shared
// single-port data memory, PE1/PE2 arbiter and MEM/WB regs.
module memory_cycle_dual #(
  parameter int DMEM_WORDS = 1024,
  parameter int DMEM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidM_PE1,
  input  logic        ValidM_PE2,
  input  logic        RegWriteM_PE1,
  input  logic        RegWriteM_PE2,
  input  logic        ResultSrcM_PE1,
  input  logic        ResultSrcM_PE2,
  input  logic        MemWriteM_PE1,
  input  logic        MemWriteM_PE2,
  input  logic [4:0]  RD_M_PE1,
  input  logic [4:0]  RD_M_PE2,
  input  logic [31:0] PCPlus4M_PE1,
  input  logic [31:0] PCPlus4M_PE2,
  input  logic [31:0] ALU_ResultM_PE1,
  input  logic [31:0] ALU_ResultM_PE2,
  input  logic [31:0] WriteDataM_PE1,
  input  logic [31:0] WriteDataM_PE2,
  output logic        StallM,
  output logic        RegWriteW_PE1,
  output logic        RegWriteW_PE2,
  output logic        ResultSrcW_PE1,
  output logic        ResultSrcW_PE2,
  output logic [4:0]  RD_W_PE1,
  output logic [4:0]  RD_W_PE2,
  output logic [31:0] PCPlus4W_PE1,
  output logic [31:0] PCPlus4W_PE2,
  output logic [31:0] ALU_ResultW_PE1,
  output logic [31:0] ALU_ResultW_PE2,
  output logic [31:0] ReadDataW_PE1,
  output logic [31:0] ReadDataW_PE2
);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  typedef struct packed {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
  } mw_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_req1;
  logic w_req2;
  logic w_conflict;

  logic               w_en;
  logic               w_we_sel;
  logic               w_we;
  logic [DMEM_AW-1:0] w_addr;
  logic [DMEM_AW-1:0] w_addr1;
  logic [DMEM_AW-1:0] w_addr2;
  logic [31:0]        w_wdata;

  logic [31:0] r_mem [DMEM_WORDS];
  logic [31:0] r_mem_q;
  logic [31:0] r_hold;
  logic        r_use_hold;

  mw_t w_m1;
  mw_t w_m2;
  mw_t r_w1;
  mw_t r_w2;

  assign w_req1 = ValidM_PE1
                & (ResultSrcM_PE1 | MemWriteM_PE1);
  assign w_req2 = ValidM_PE2
                & (ResultSrcM_PE2 | MemWriteM_PE2);

  assign w_addr1 = ALU_ResultM_PE1[DMEM_AW+1:2];
  assign w_addr2 = ALU_ResultM_PE2[DMEM_AW+1:2];

  assign w_m1 = {RegWriteM_PE1 & ValidM_PE1,
                 ResultSrcM_PE1, RD_M_PE1,
                 PCPlus4M_PE1, ALU_ResultM_PE1};
  assign w_m2 = {RegWriteM_PE2 & ValidM_PE2,
                 ResultSrcM_PE2, RD_M_PE2,
                 PCPlus4M_PE2, ALU_ResultM_PE2};

  // state register: NORMAL or serving PE2's deferred access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_NORMAL;
    else      r_state <= w_state_nxt;
  end

  // next state, conflict detect and stall
  always_comb begin
    w_state_nxt = r_state;
    w_conflict  = 1'b0;
    StallM      = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (w_req1 && w_req2) begin
          w_conflict  = 1'b1;
          w_state_nxt = ST_SECOND;
        end
      end
      ST_SECOND: w_state_nxt = ST_NORMAL;
      default:   w_state_nxt = ST_NORMAL;
    endcase
    StallM = w_conflict & rst;
  end

  // memory port arbiter: PE1 first, PE2 in SECOND
  always_comb begin
    w_en     = 1'b0;
    w_we_sel = 1'b0;
    w_addr   = w_addr1;
    w_wdata  = WriteDataM_PE1;
    if (r_state == ST_SECOND) begin
      w_en     = w_req2;
      w_we_sel = MemWriteM_PE2;
      w_addr   = w_addr2;
      w_wdata  = WriteDataM_PE2;
    end else if (w_req1) begin
      w_en     = 1'b1;
      w_we_sel = MemWriteM_PE1;
    end else if (w_req2) begin
      w_en     = 1'b1;
      w_we_sel = MemWriteM_PE2;
      w_addr   = w_addr2;
      w_wdata  = WriteDataM_PE2;
    end
    w_we = w_en & w_we_sel & rst;
  end

  // memory array write; contents are never reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_wdata;
  end

  // synchronous read port (old data on a same-cycle write)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_mem_q <= '0;
    else if (w_en) r_mem_q <= r_mem[w_addr];
  end

  // park PE1's read data while PE2 takes the port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold     <= '0;
      r_use_hold <= 1'b0;
    end else begin
      if (r_state == ST_SECOND) r_hold <= r_mem_q;
      r_use_hold <= (r_state == ST_SECOND);
    end
  end

  // MEM/WB registers: bubble on conflict, else load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w1 <= '0;
      r_w2 <= '0;
    end else if (w_conflict) begin
      r_w1.rw <= 1'b0;
      r_w2.rw <= 1'b0;
    end else begin
      r_w1 <= w_m1;
      r_w2 <= w_m2;
    end
  end

  assign RegWriteW_PE1   = r_w1.rw;
  assign RegWriteW_PE2   = r_w2.rw;
  assign ResultSrcW_PE1  = r_w1.rs;
  assign ResultSrcW_PE2  = r_w2.rs;
  assign RD_W_PE1        = r_w1.rd;
  assign RD_W_PE2        = r_w2.rd;
  assign PCPlus4W_PE1    = r_w1.pc4;
  assign PCPlus4W_PE2    = r_w2.pc4;
  assign ALU_ResultW_PE1 = r_w1.alu;
  assign ALU_ResultW_PE2 = r_w2.alu;
  assign ReadDataW_PE1   = r_use_hold ? r_hold : r_mem_q;
  assign ReadDataW_PE2   = r_mem_q;

endmodule

// File: tb/tb_memory_cycle_dual.sv
// tb_memory_cycle_dual: directed and random checks of the
// dual-PE memory stage against a transaction-level model.
module tb_memory_cycle_dual;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ValidM_PE1, ValidM_PE2;
  logic        RegWriteM_PE1, RegWriteM_PE2;
  logic        ResultSrcM_PE1, ResultSrcM_PE2;
  logic        MemWriteM_PE1, MemWriteM_PE2;
  logic [4:0]  RD_M_PE1, RD_M_PE2;
  logic [31:0] PCPlus4M_PE1, PCPlus4M_PE2;
  logic [31:0] ALU_ResultM_PE1, ALU_ResultM_PE2;
  logic [31:0] WriteDataM_PE1, WriteDataM_PE2;
  logic        StallM;
  logic        RegWriteW_PE1, RegWriteW_PE2;
  logic        ResultSrcW_PE1, ResultSrcW_PE2;
  logic [4:0]  RD_W_PE1, RD_W_PE2;
  logic [31:0] PCPlus4W_PE1, PCPlus4W_PE2;
  logic [31:0] ALU_ResultW_PE1, ALU_ResultW_PE2;
  logic [31:0] ReadDataW_PE1, ReadDataW_PE2;

  memory_cycle_dual #(.DMEM_WORDS(1024), .DMEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .ValidM_PE1(ValidM_PE1), .ValidM_PE2(ValidM_PE2),
    .RegWriteM_PE1(RegWriteM_PE1), .RegWriteM_PE2(RegWriteM_PE2),
    .ResultSrcM_PE1(ResultSrcM_PE1), .ResultSrcM_PE2(ResultSrcM_PE2),
    .MemWriteM_PE1(MemWriteM_PE1), .MemWriteM_PE2(MemWriteM_PE2),
    .RD_M_PE1(RD_M_PE1), .RD_M_PE2(RD_M_PE2),
    .PCPlus4M_PE1(PCPlus4M_PE1), .PCPlus4M_PE2(PCPlus4M_PE2),
    .ALU_ResultM_PE1(ALU_ResultM_PE1), .ALU_ResultM_PE2(ALU_ResultM_PE2),
    .WriteDataM_PE1(WriteDataM_PE1), .WriteDataM_PE2(WriteDataM_PE2),
    .StallM(StallM),
    .RegWriteW_PE1(RegWriteW_PE1), .RegWriteW_PE2(RegWriteW_PE2),
    .ResultSrcW_PE1(ResultSrcW_PE1), .ResultSrcW_PE2(ResultSrcW_PE2),
    .RD_W_PE1(RD_W_PE1), .RD_W_PE2(RD_W_PE2),
    .PCPlus4W_PE1(PCPlus4W_PE1), .PCPlus4W_PE2(PCPlus4W_PE2),
    .ALU_ResultW_PE1(ALU_ResultW_PE1), .ALU_ResultW_PE2(ALU_ResultW_PE2),
    .ReadDataW_PE1(ReadDataW_PE1), .ReadDataW_PE2(ReadDataW_PE2)
  );

  always #5 clk = ~clk;

  // op: 0 = ALU only, 1 = load, 2 = store
  typedef struct {
    bit          v;
    bit          rw;
    int          op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
  } op_t;

  logic [31:0] mdl [1024];
  bit          kn  [1024];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic op_t mk(input bit v, input bit rw,
                             input int op,
                             input logic [31:0] a,
                             input logic [31:0] wd);
    op_t o;
    o.v  = v;
    o.rw = rw;
    o.op = op;
    o.a  = a;
    o.wd = wd;
    o.pc = $urandom;
    o.rd = 5'($urandom);
    return o;
  endfunction

  function automatic op_t rnd();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_F003)
      | (32'($urandom_range(0, 15)) << 2);
    return mk($urandom_range(0, 7) != 0, 1'($urandom),
              $urandom_range(0, 2), a, $urandom);
  endfunction

  task automatic drive(input op_t p1, input op_t p2);
    ValidM_PE1      = p1.v;
    RegWriteM_PE1   = p1.rw;
    ResultSrcM_PE1  = (p1.op == 1);
    MemWriteM_PE1   = (p1.op == 2);
    RD_M_PE1        = p1.rd;
    PCPlus4M_PE1    = p1.pc;
    ALU_ResultM_PE1 = p1.a;
    WriteDataM_PE1  = p1.wd;
    ValidM_PE2      = p2.v;
    RegWriteM_PE2   = p2.rw;
    ResultSrcM_PE2  = (p2.op == 1);
    MemWriteM_PE2   = (p2.op == 2);
    RD_M_PE2        = p2.rd;
    PCPlus4M_PE2    = p2.pc;
    ALU_ResultM_PE2 = p2.a;
    WriteDataM_PE2  = p2.wd;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, StallM, 0);
    chk({tag, ".rw1"}, RegWriteW_PE1, 0);
    chk({tag, ".rw2"}, RegWriteW_PE2, 0);
    chk({tag, ".rs1"}, ResultSrcW_PE1, 0);
    chk({tag, ".rs2"}, ResultSrcW_PE2, 0);
    chk({tag, ".rd1"}, RD_W_PE1, 0);
    chk({tag, ".rd2"}, RD_W_PE2, 0);
    chk({tag, ".pc1"}, PCPlus4W_PE1, 0);
    chk({tag, ".pc2"}, PCPlus4W_PE2, 0);
    chk({tag, ".alu1"}, ALU_ResultW_PE1, 0);
    chk({tag, ".alu2"}, ALU_ResultW_PE2, 0);
    chk({tag, ".rdat1"}, ReadDataW_PE1, 0);
    chk({tag, ".rdat2"}, ReadDataW_PE2, 0);
  endtask

  // one M-stage bundle: program-order model, then W checks
  task automatic issue(input op_t p1, input op_t p2,
                       input string tag);
    bit r1, r2, conf, k1, k2;
    logic [31:0] e1, e2;
    int i1, i2;
    k1 = 0;
    k2 = 0;
    e1 = '0;
    e2 = '0;
    drive(p1, p2);
    r1 = p1.v && (p1.op != 0);
    r2 = p2.v && (p2.op != 0);
    conf = r1 && r2;
    i1 = widx(p1.a);
    i2 = widx(p2.a);
    if (r1) begin
      if (p1.op == 2) begin
        mdl[i1] = p1.wd;
        kn[i1]  = 1;
      end else begin
        e1 = mdl[i1];
        k1 = kn[i1];
      end
    end
    if (r2) begin
      if (p2.op == 2) begin
        mdl[i2] = p2.wd;
        kn[i2]  = 1;
      end else begin
        e2 = mdl[i2];
        k2 = kn[i2];
      end
    end
    #1;
    chk({tag, ".stall"}, StallM, conf);
    if (conf) begin
      @(posedge clk);
      #1;
      chk({tag, ".bub1"}, RegWriteW_PE1, 0);
      chk({tag, ".bub2"}, RegWriteW_PE2, 0);
      chk({tag, ".stall2"}, StallM, 0);
    end
    @(posedge clk);
    #1;
    chk({tag, ".rw1"}, RegWriteW_PE1, p1.rw & p1.v);
    chk({tag, ".rw2"}, RegWriteW_PE2, p2.rw & p2.v);
    chk({tag, ".rs1"}, ResultSrcW_PE1, p1.op == 1);
    chk({tag, ".rs2"}, ResultSrcW_PE2, p2.op == 1);
    chk({tag, ".rd1"}, RD_W_PE1, p1.rd);
    chk({tag, ".rd2"}, RD_W_PE2, p2.rd);
    chk({tag, ".pc1"}, PCPlus4W_PE1, p1.pc);
    chk({tag, ".pc2"}, PCPlus4W_PE2, p2.pc);
    chk({tag, ".alu1"}, ALU_ResultW_PE1, p1.a);
    chk({tag, ".alu2"}, ALU_ResultW_PE2, p2.a);
    if (r1 && p1.op == 1 && k1)
      chk({tag, ".rdat1"}, ReadDataW_PE1, e1);
    if (r2 && p2.op == 1 && k2)
      chk({tag, ".rdat2"}, ReadDataW_PE2, e2);
  endtask

  initial begin
    op_t idle;
    op_t q1, q2;
    idle = mk(0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) kn[i] = 0;

    // reset with random, conflicting inputs
    drive(mk(1, 1, 1, $urandom, $urandom),
          mk(1, 1, 2, $urandom, $urandom));
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    drive(rnd(), rnd());
    #1;
    chk({"rst", ".stall_r"}, StallM, 0);
    rst = 1'b1;

    // single access: store then load on PE1
    issue(mk(1, 0, 2, 32'h40, 32'hDEADBEEF),
          mk(1, 1, 0, $urandom, 0), "st40");
    issue(mk(1, 1, 1, 32'h40, 0),
          mk(1, 1, 0, $urandom, 0), "ld40");
    chk("ld40.lit", ReadDataW_PE1, 32'hDEADBEEF);
    issue(mk(1, 1, 0, $urandom, 0),
          mk(1, 0, 2, 32'h44, 32'h12345678), "st44");

    // dual load, one stall cycle
    issue(mk(1, 1, 1, 32'h40, 0),
          mk(1, 1, 1, 32'h44, 0), "dld");
    chk("dld.lit1", ReadDataW_PE1, 32'hDEADBEEF);
    chk("dld.lit2", ReadDataW_PE2, 32'h12345678);

    // PE1 store then PE2 load of the same word
    issue(mk(1, 0, 2, 32'h80, 32'h11),
          mk(1, 1, 1, 32'h80, 0), "hz");
    chk("hz.lit", ReadDataW_PE2, 32'h11);

    // dual store same word, then read incl. wrap alias
    issue(mk(1, 0, 2, 32'h100, 32'hA),
          mk(1, 0, 2, 32'h100, 32'hB), "dst");
    issue(mk(1, 1, 1, 32'h100, 0),
          mk(1, 1, 1, 32'h1100, 0), "dstld");
    chk("dstld.lit1", ReadDataW_PE1, 32'hB);
    chk("dstld.lit2", ReadDataW_PE2, 32'hB);

    // reset while PE2's store is pending in SECOND
    issue(mk(1, 0, 2, 32'h204, 32'h55), idle, "pre204");
    q1 = mk(1, 0, 2, 32'h200, 32'h1);
    q2 = mk(1, 0, 2, 32'h204, 32'h2);
    drive(q1, q2);
    #1;
    chk("rs2.stall", StallM, 1);
    @(posedge clk);
    #1;
    mdl[widx(32'h200)] = 32'h1;
    kn[widx(32'h200)]  = 1;
    chk("rs2.sec", StallM, 0);
    rst = 1'b0;
    #1;
    chk_zero("rs2.a");
    @(posedge clk);
    #1;
    chk_zero("rs2.b");
    drive(idle, idle);
    rst = 1'b1;
    issue(mk(1, 1, 1, 32'h200, 0),
          mk(1, 1, 1, 32'h204, 0), "rs2ld");
    chk("rs2ld.lit1", ReadDataW_PE1, 32'h1);
    chk("rs2ld.lit2", ReadDataW_PE2, 32'h55);

    // random bundles
    for (int n = 0; n < 300; n++) begin
      issue(rnd(), rnd(), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
